// File: rtl/df_pair_cmd_driver_if.sv
// df_pair_cmd_driver_if: request handshake plus ic1500 d/f command and q readback bundle
// Ports: req_valid/req_ready/req_q request side; d0,f0,d1,f1 commands; q0,q1 readback;
//        done/mismatch pulses, sticky err, cmd_cnt/err_cnt saturating counters (CNT_W wide)
interface df_pair_cmd_driver_if #(parameter int CNT_W = 8);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_q;
  logic             d0, f0, d1, f1;
  logic             q0, q1;
  logic             done, mismatch, err;
  logic [CNT_W-1:0] cmd_cnt, err_cnt;
  modport master (output req_valid, req_q, q0, q1,
                  input  req_ready, d0, f0, d1, f1, done, mismatch, err, cmd_cnt, err_cnt);
  modport slave  (input  req_valid, req_q, q0, q1,
                  output req_ready, d0, f0, d1, f1, done, mismatch, err, cmd_cnt, err_cnt);
endinterface

// File: rtl/df_pair_cmd_driver.sv
// df_pair_cmd_driver: drives a 2-bit target into the ic1500 DF pair and verifies it by readback
// Ports: clk, rst (sync, active-high); bus (slave modport of df_pair_cmd_driver_if)
// Option: DF_CMD_TOGGLE_EN selects toggle (11) instead of force for bits that must change
module df_pair_cmd_driver #(
  parameter int CNT_W      = 8,
  parameter int SETTLE_CYC = 1
) (
  input logic                clk,
  input logic                rst,
  df_pair_cmd_driver_if.slave bus
);
  typedef enum logic [2:0] {INIT, IDLE, DRIVE, WAIT, CHECK} state_t;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  state_t           r_state, w_next;
  logic [3:0]       r_df, w_df, w_cmd;
  logic             r_ready, w_ready, r_done, w_done, r_mis, w_mis, r_err, w_err, w_hs;
  logic [1:0]       r_tgt, w_tgt, r_sh, w_sh, w_q;
  logic [CNT_W-1:0] r_cc, w_cc, r_ec, w_ec;
  logic [3:0]       r_wc, w_wc;
  function automatic logic [1:0] bit_cmd(input logic t, input logic s);
`ifdef DF_CMD_TOGGLE_EN
    return (t == s) ? 2'b00 : 2'b11;
`else
    return (t == s) ? 2'b00 : {t, ~t};
`endif
  endfunction
  // d/f is registered from the handshake decision so the command is on the pins during DRIVE
  always_comb begin
    w_q     = {bus.q1, bus.q0};
    w_hs    = bus.req_valid && r_ready;
    w_cmd   = {bit_cmd(bus.req_q[1], r_sh[1]), bit_cmd(bus.req_q[0], r_sh[0])};
    w_next  = r_state;
    w_df    = 4'b0000;
    w_ready = 1'b0;
    w_done  = 1'b0;
    w_mis   = 1'b0;
    w_err   = r_err;
    w_tgt   = r_tgt;
    w_sh    = r_sh;
    w_cc    = r_cc;
    w_ec    = r_ec;
    w_wc    = r_wc;
    case (r_state)
      INIT: begin
        w_next = IDLE;
        w_df   = 4'b0101;
        w_sh   = 2'b00;
      end
      IDLE: begin
        w_ready = !w_hs;
        w_next  = w_hs ? DRIVE : IDLE;
        w_tgt   = w_hs ? bus.req_q : r_tgt;
        w_df    = w_hs ? w_cmd : 4'b0000;
        w_cc    = (w_hs && r_cc != CNT_MAX) ? r_cc + 1'b1 : r_cc;
      end
      DRIVE: begin
        w_next = (SETTLE_CYC == 0) ? CHECK : WAIT;
        w_wc   = 4'd0;
      end
      WAIT: begin
        w_wc   = r_wc + 4'd1;
        w_next = (r_wc == 4'(SETTLE_CYC - 1)) ? CHECK : WAIT;
      end
      CHECK: begin
        w_next  = IDLE;
        w_ready = 1'b1;
        w_done  = 1'b1;
        w_mis   = w_q != r_tgt;
        w_err   = r_err | w_mis;
        w_ec    = (w_mis && r_ec != CNT_MAX) ? r_ec + 1'b1 : r_ec;
        w_sh    = w_q;
      end
      default: w_next = INIT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= INIT;
      r_df    <= 4'b0000;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_mis   <= 1'b0;
      r_err   <= 1'b0;
      r_tgt   <= 2'b00;
      r_sh    <= 2'b00;
      r_cc    <= '0;
      r_ec    <= '0;
      r_wc    <= 4'd0;
    end else begin
      r_state <= w_next;
      r_df    <= w_df;
      r_ready <= w_ready;
      r_done  <= w_done;
      r_mis   <= w_mis;
      r_err   <= w_err;
      r_tgt   <= w_tgt;
      r_sh    <= w_sh;
      r_cc    <= w_cc;
      r_ec    <= w_ec;
      r_wc    <= w_wc;
    end
  end
  assign bus.req_ready = r_ready;
  assign {bus.d1, bus.f1, bus.d0, bus.f0} = r_df;
  assign bus.done     = r_done;
  assign bus.mismatch = r_mis;
  assign bus.err      = r_err;
  assign bus.cmd_cnt  = r_cc;
  assign bus.err_cnt  = r_ec;
endmodule
